nibble_seq_adder: RTL and testbench

Multi-cycle wide adder that splits two NIBBLES×4-bit operands into nibbles and feeds them one per clock, LSB nibble first, into the team's 4-bit ripple adder `full_adder`. The registered carry chains between nibbles, and the nibble results are shifted into a result register. This block is the sequencing stage directly upstream of `full_adder`. It lets wide additions reuse one 4-bit datapath at a cost of NIBBLES cycles of latency.

---
 rtl/nsa_pkg.sv | 25 ++
 rtl/full_adder.sv | 21 ++
 rtl/nibble_seq_adder.sv | 137 +++++++++++++
 tb/tb_nibble_seq_adder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// nsa_pkg: shared definitions for nibble_seq_adder.
//   state_t  : sequencer states (IDLE, RUN, DONE)
//   NIBBLE_W : width of one adder slice (4)
//   clog2()  : width of the nibble index register for a given slice count
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, never below 1 so the index register always has a bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: purely combinational 4-bit ripple adder slice.
// Ports:
//   x, y : 4-bit addends
//   cin  : carry in
//   z    : 4-bit sum
//   cout : carry out
module full_adder (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] z,
    output logic       cout
);

    logic [4:0] total;

    assign total = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    assign z     = total[3:0];
    assign cout  = total[4];

endmodule

// File: rtl/nibble_seq_adder.sv
// nibble_seq_adder: wide adder that reuses one 4-bit full_adder slice,
// feeding operand nibbles LSB first, one per clock, with a registered carry.
// Result appears NIBBLES cycles after an accepted start.
//
// Optional feature macro: NSA_SUB_EN (adds the `sub` port; when sub=1 the
// operation becomes a - b, cout=1 meaning no borrow).
//
// Ports:
//   clk   : clock, all state on rising edge
//   rst   : synchronous active-high reset
//   start : operation request, honoured only outside RUN
//   a, b  : W-bit operands, W = 4*NIBBLES, latched on accepted start
//   cin   : carry into nibble 0, latched on accepted start
//   sub   : subtract request (only with NSA_SUB_EN)
//   busy  : high while nibbles are being processed
//   done  : one-cycle pulse when sum/cout are updated
//   sum   : result, held between completions
//   cout  : carry out of the top nibble, held with sum
module nibble_seq_adder
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                        cin,
`ifdef NSA_SUB_EN
    input  logic                        sub,
`endif
    output logic                        busy,
    output logic                        done,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                        cout
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int PW    = W - NIBBLE_W;
    localparam int IDX_W = clog2(NIBBLES);

    state_t             state;
    state_t             state_nxt;
    logic [W-1:0]       a_sh;
    logic [W-1:0]       b_sh;
    logic [PW-1:0]      part;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic               last;

    logic [NIBBLE_W-1:0] add_z;
    logic                add_cout;
    logic [W-1:0]        cat;

    logic [W-1:0]        b_in;
    logic                c_in;

    // Subtraction is a + ~b + 1, so the operand inversion and forced carry
    // are applied once at latch time; the RUN datapath is identical.
`ifdef NSA_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    full_adder u_adder (
        .x    (a_sh[NIBBLE_W-1:0]),
        .y    (b_sh[NIBBLE_W-1:0]),
        .cin  (carry),
        .z    (add_z),
        .cout (add_cout)
    );

    // Partial result holds completed nibbles; the new nibble enters at the
    // top, so after the last slice {z, part} is the full sum.
    assign cat  = {add_z, part};
    assign last = (idx == IDX_W'(NIBBLES - 1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start ? RUN : IDLE;
            RUN:        state_nxt = last ? DONE : RUN;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            part  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_in;
                        carry <= c_in;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> NIBBLE_W;
                    b_sh  <= b_sh >> NIBBLE_W;
                    carry <= add_cout;
                    part  <= cat[W-1:NIBBLE_W];
                    idx   <= idx + IDX_W'(1);
                    if (last) begin
                        sum  <= cat;
                        cout <= add_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_seq_adder.sv
module tb_nibble_seq_adder;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef NSA_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;

    logic [W:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] esum;
        logic         ecout;
    } vec_t;

    vec_t vecs[5];

    nibble_seq_adder #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef NSA_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expected {cout,sum}.
    always @(negedge clk) begin
        logic [W:0] e;
        if (busy && done) begin
            total++;
            bad++;
            $display("FAIL busy_done_overlap: busy=%0b done=%0b", busy, done);
        end
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: sum=0x%0h with nothing expected", sum);
            end else begin
                e = exp_q.pop_front();
                chk("sb_sum", 32'(sum), 32'(e[W-1:0]));
                chk("sb_cout", 32'(cout), 32'(e[W]));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic [W-1:0] es, input logic ec);
        int  busy_cnt;
        int  lat;
        bit  got;
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        exp_q.push_back({ec, es});
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0; lat = 0; got = 0;
        for (int c = 1; c <= 20; c++) begin
            if (done) begin
                lat = c - 1;
                got = 1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("latency", 32'(lat), 32'(NIBBLES));
        chk("busy_cycles", 32'(busy_cnt), 32'(NIBBLES));
        @(negedge clk);
        chk("done_width", 32'(done), 32'd0);
    endtask

    initial begin
        int t0;
        int d_first;
        int d_prev;
        int n_done;
        int dc0;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef NSA_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].esum, vecs[i].ecout);
        end

        // Start held high: one result every NIBBLES+1 cycles.
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        repeat (3) exp_q.push_back({1'b0, 16'h0100});
        t0 = 0; n_done = 0; d_first = 0; d_prev = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (n_done == 1) d_first = c;
                else chk("b2b_period", 32'(c - d_prev), 32'(NIBBLES + 1));
                d_prev = c;
                if (n_done == 3) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        chk("b2b_count", 32'(n_done), 32'd3);
        chk("b2b_first_latency", 32'(d_first - 1), 32'(NIBBLES));
        @(negedge clk);
        @(negedge clk);
        chk("b2b_idle", 32'(busy), 32'd0);

        // Start during RUN is ignored.
        dc0 = done_cnt;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        exp_q.push_back({1'b0, 16'h3333});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hAAAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("ignore_done_count", 32'(done_cnt - dc0), 32'd1);
        chk("ignore_sum", 32'(sum), 32'h3333);
        chk("ignore_idle", 32'(busy), 32'd0);

        // Reset in the middle of RUN abandons the operation.
        dc0 = done_cnt;
        @(negedge clk);
        a = 16'h4321; b = 16'h1111; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        repeat (8) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt - dc0), 32'd0);

        run_op(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0);

`ifdef NSA_SUB_EN
        sub = 1'b1;
        run_op(16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
        run_op(16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
        sub = 1'b0;
`endif

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
